uart_line_rx: RTL
=================

# uart_line_rx

Line-oriented receive buffer that sits directly behind `uart_rx` on its `rvalid/rready/rdata` byte stream. It collects received bytes into a local buffer until a terminator byte (default `\n`) arrives or the buffer fills. It then presents the completed line to a downstream consumer as a byte stream with a last-byte marker. It is the consumer-side counterpart of the ROM-driven string sender used in simulation and on the board, and it also serves as a command-line front end for future UART control logic.

## Interface
- `DEPTH`, 16: buffer size in bytes; power of two, minimum 2.
- `TERM`, 8'h0A: line terminator byte.

- `clk_i`  in  1: clock.
- `rst_i`  in  1: synchronous reset, active-high.
- `rvalid_i`  in  1: byte valid, driven by `uart_rx`.
- `rready_o`  out  1: byte accept, driven back to `uart_rx`.
- `rdata_i`  in  8: received byte.
- `line_valid_o`  out  1: line byte valid.
- `line_ready_i`  in  1: downstream accept.
- `line_data_o`  out  8: current line byte.
- `line_last_o`  out  1: final byte of the line; qualified by `line_valid_o`.
- `line_len_o`  out  $clog2(DEPTH)+1: byte count of the current line; stable throughout DRAIN.
- `ovf_o`  out  1: the current line was closed by a full buffer, not by `TERM`.

## Operation
- Two states: COLLECT and DRAIN. Reset state is COLLECT.
- Byte accept: a byte is accepted in any cycle where `rvalid_i && rready_o`.
- COLLECT:
  - `rready_o`=1 and `line_valid_o`=0.
  - Each accepted byte is written to `buf[wptr]` and `wptr` increments.
  - The line closes when the accepted byte equals `TERM`, or when it is written at `wptr==DEPTH-1`.
  - On close: `line_len_o` = `wptr`+1, `ovf_o` = (byte != `TERM`), state moves to DRAIN.
- DRAIN:
  - `rready_o`=0, so `uart_rx` holds its byte and applies backpressure.
  - `line_valid_o`=1 and `line_data_o`=`buf[rptr]`, a combinational read of the registered buffer.
  - `line_last_o` = (`rptr`==`line_len_o`-1).
  - Each `line_valid_o && line_ready_i` handshake increments `rptr`.
  - On the handshake with `line_last_o`=1: `wptr`, `rptr` and `ovf_o` clear, `line_len_o` clears, and state returns to COLLECT.
- Payload: byte 8'h00 and every other non-`TERM` value are ordinary data.
- Output stability: `line_data_o`, `line_last_o` and `line_len_o` hold while `line_valid_o && !line_ready_i`.

## Timing
- Reset values, held while `rst_i`=1:
  - state=COLLECT, `wptr`=`rptr`=0.
  - `rready_o`=0, `line_valid_o`=0, `line_last_o`=0, `line_data_o`=`buf[0]` (contents don't-care), `line_len_o`=0, `ovf_o`=0.
- `rready_o` is a register: 1 in the first cycle after `rst_i` falls.
- Accept at cycle N of the closing byte:
  - `rready_o`=0 and `line_valid_o`=1 at N+1.
  - No byte is accepted at N+1.
- Final drain handshake at cycle M: `line_valid_o`=0 and `rready_o`=1 at M+1.
- Minimum line turnaround: length + 1 cycles with `line_ready_i` tied high.
- Reset mid-line, in either state: the partial or pending line is discarded, with no output handshake.
- `rvalid_i` while `rready_o`=0 has no effect.
- `wptr` never wraps. The full condition closes the line before `wptr` reaches `DEPTH`.

## Configuration
- `UART_LINE_RX_STRIP_EN`
  - Defined:
    - `TERM` is not stored, and `line_len_o` excludes it.
    - A `TERM` at `wptr`==0 (empty line) is consumed and dropped; the block stays in COLLECT.
    - A full buffer still closes with `ovf_o`=1.
    - A `TERM` arriving next in COLLECT is consumed as an empty line and dropped.
  - Undefined:
    - `TERM` is stored as the final byte.
    - An empty line drains as one byte `TERM` with `line_len_o`=1, `line_last_o`=1.

## Test plan
- Reset then "Hello\n", `line_ready_i`=1, strip off:
  - Expect 6 bytes 48 65 6C 6C 6F 0A, with `line_last_o` only on 0A.
  - `line_len_o`=6, `ovf_o`=0.
  - `rready_o` low exactly from the cycle after 0A accept through the last handshake.
- Same stimulus with `UART_LINE_RX_STRIP_EN`: expect 5 bytes, `line_len_o`=5; a following lone "\n" produces no `line_valid_o`.
- 20 bytes 0x41 with no `TERM`, `DEPTH`=16:
  - First line is 16×0x41, `line_len_o`=16, `ovf_o`=1.
  - Remaining 4 bytes plus "\n" form the next line with `ovf_o`=0.
- Backpressure: "AB\n" with `line_ready_i` toggling 0/1 each cycle.
  - Outputs are held while stalled; exactly 3 handshakes occur.
  - `uart_rx` `rvalid` stays high with `rready_o`=0 during DRAIN.
- `rst_i` pulsed after "AB" accepted, then "C\n": expect a line of 43 0A only, `line_len_o`=2.
- Back-to-back: "Hi\n" immediately followed by "Yo\n" with no idle gaps; both lines are delivered intact and in order, with no byte dropped.

Source files
------------

// File: rtl/uart_line_rx.sv
// Line receive buffer: gathers bytes from uart_rx until TERM or a full buffer, then drains the line.
// Optional macro UART_LINE_RX_STRIP_EN: drop TERM from stored lines and discard empty lines.
module uart_line_rx #(
    parameter int         DEPTH = 16,
    parameter logic [7:0] TERM  = 8'h0A
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    rvalid_i,
    output logic                    rready_o,
    input  logic [7:0]              rdata_i,
    output logic                    line_valid_o,
    input  logic                    line_ready_i,
    output logic [7:0]              line_data_o,
    output logic                    line_last_o,
    output logic [$clog2(DEPTH):0]  line_len_o,
    output logic                    ovf_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t        state, state_next;
    logic [PW-1:0] wptr, wptr_next;
    logic [PW-1:0] rptr, rptr_next;
    logic [LW-1:0] len, len_next;
    logic          ovf, ovf_next;
    logic          mem_we;
    logic          accept, is_term, at_full;
    logic [7:0]    mem [DEPTH];

    assign accept  = rvalid_i && rready_o;
    assign is_term = (rdata_i == TERM);
    assign at_full = (wptr == PW'(DEPTH - 1));

    assign line_valid_o = (state == DRAIN);
    assign line_data_o  = mem[rptr];
    assign line_last_o  = line_valid_o && ({1'b0, rptr} == len - 1'b1);
    assign line_len_o   = len;
    assign ovf_o        = ovf;

    always_comb begin
        state_next = state;
        wptr_next  = wptr;
        rptr_next  = rptr;
        len_next   = len;
        ovf_next   = ovf;
        mem_we     = 1'b0;
        case (state)
            COLLECT: begin
                if (accept) begin
`ifdef UART_LINE_RX_STRIP_EN
                    if (is_term) begin
                        // An empty line is swallowed without ever leaving COLLECT.
                        if (wptr != '0) begin
                            state_next = DRAIN;
                            len_next   = {1'b0, wptr};
                            ovf_next   = 1'b0;
                        end
                    end else begin
                        mem_we    = 1'b1;
                        wptr_next = wptr + 1'b1;
                        if (at_full) begin
                            state_next = DRAIN;
                            len_next   = LW'(DEPTH);
                            ovf_next   = 1'b1;
                        end
                    end
`else
                    mem_we    = 1'b1;
                    wptr_next = wptr + 1'b1;
                    if (is_term || at_full) begin
                        state_next = DRAIN;
                        len_next   = {1'b0, wptr} + 1'b1;
                        ovf_next   = !is_term;
                    end
`endif
                end
            end
            DRAIN: begin
                if (line_ready_i) begin
                    rptr_next = rptr + 1'b1;
                    if (line_last_o) begin
                        state_next = COLLECT;
                        wptr_next  = '0;
                        rptr_next  = '0;
                        len_next   = '0;
                        ovf_next   = 1'b0;
                    end
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // rready_o is registered so uart_rx sees backpressure from the cycle after the closing byte.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= COLLECT;
            wptr     <= '0;
            rptr     <= '0;
            len      <= '0;
            ovf      <= 1'b0;
            rready_o <= 1'b0;
        end else begin
            state    <= state_next;
            wptr     <= wptr_next;
            rptr     <= rptr_next;
            len      <= len_next;
            ovf      <= ovf_next;
            rready_o <= (state_next == COLLECT);
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[wptr] <= rdata_i;
        end
    end

endmodule
